// File: rtl/fdb_pkg.sv
// fdb_pkg: constants and types shared by the fetch/decode buffer.
//   NOP_INSTR    - instruction presented to decode while the buffer is empty
//   HALT_INSTR   - encoding that closes the fetch side when halt detection
//                  is built in (FDB_HALT_DETECT_EN)
//   IW_DEFAULT   - default instruction / PC width
//   fdb_entry_t  - one buffered {instr, pc_next} pair at the default width
package fdb_pkg;

    localparam int unsigned IW_DEFAULT = 16;

    localparam logic [IW_DEFAULT-1:0] NOP_INSTR  = 16'h0800;
    localparam logic [IW_DEFAULT-1:0] HALT_INSTR = 16'h0000;

    typedef struct packed {
        logic [IW_DEFAULT-1:0] instr;
        logic [IW_DEFAULT-1:0] pc_next;
    } fdb_entry_t;

endpackage

// File: rtl/fdb_entry_store.sv
// fdb_entry_store: DEPTH x W register array backing the buffer.
//   clk    - system clock
//   we     - write enable, writes wdata at waddr on the rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read data
// No reset: contents are only observed after they have been written.
module fdb_entry_store
    import fdb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 2 * IW_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: small FIFO of {instruction, PC+2} pairs between the
// fetch and decode stages, valid/ready on both sides.
//   clk          - system clock
//   rst          - asynchronous reset, active low
//   in_valid     - fetch presents an instruction
//   in_ready     - buffer accepts this cycle (registered state only)
//   in_instr     - fetched instruction
//   in_pc_next   - PC+2 of the fetched instruction
//   flush        - synchronous discard of all entries, wins over push/pop
//   out_valid    - head entry valid
//   out_ready    - decode consumes the head entry
//   out_instr    - head instruction, NOP when empty
//   out_pc_next  - head PC+2, zero when empty
//   count        - registered occupancy
//   halted       - HALT accepted, fetch side closed
// Build option FDB_HALT_DETECT_EN: when defined, pushing HALT_INSTR closes
// the fetch side until flush or reset; when undefined, halted is tied low
// and HALT is ordinary data.
module fetch_decode_buffer
    import fdb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IW    = IW_DEFAULT,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [IW-1:0] in_pc_next,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [IW-1:0] out_pc_next,
    output logic [CW-1:0] count,
    output logic          halted
);

    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [2*IW-1:0] wdata;
    logic [2*IW-1:0] rdata;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

`ifdef FDB_HALT_DETECT_EN
    logic halted_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else if (flush) begin
            halted_q <= 1'b0;
        end else if (push && (in_instr == IW'(HALT_INSTR))) begin
            halted_q <= 1'b1;
        end
    end

    assign halted   = halted_q;
    assign in_ready = !full && !halted_q;
`else
    assign halted   = 1'b0;
    assign in_ready = !full;
`endif

    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign wdata = {in_instr, in_pc_next};

    fdb_entry_store #(
        .DEPTH (DEPTH),
        .W     (2 * IW)
    ) u_store (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (tail_q),
        .wdata (wdata),
        .raddr (head_q),
        .rdata (rdata)
    );

    assign out_instr   = empty ? IW'(NOP_INSTR) : rdata[2*IW-1:IW];
    assign out_pc_next = empty ? '0 : rdata[IW-1:0];
    assign count       = count_q;

endmodule
